bin2bcd_seq: RTL
================

Name: bin2bcd_seq

Overview:
Parametrised, multi-cycle binary-to-BCD converter. It uses shift-and-add-3 (double dabble) and performs one shift per clock.
- Successor to the team's combinational 10-bit converter; generalised in input width and digit count.
- Adds a valid/ready handshake on both sides, an overflow flag and a leading-zero blanking mask.
- Sits between datapath counters/ADC values and the 7-segment display multiplexer.

Parameters:
BIN_W, 10, width of the unsigned binary input (>=2)
DIGITS, 4, number of BCD digits produced (>=1); output is 4*DIGITS bits

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  bin is valid this cycle
in_ready  output  1  converter can accept bin this cycle
bin  input  BIN_W  unsigned binary value to convert
out_valid  output  1  bcd/ovf/sig_mask are valid
out_ready  input  1  consumer accepts the result this cycle
bcd  output  4*DIGITS  packed BCD; digit d at bits [4d+3:4d], digit 0 is least significant
ovf  output  1  value exceeded 10^DIGITS-1; bcd then holds value mod 10^DIGITS
sig_mask  output  DIGITS  bit d=1 if digit d is significant (digit 0 always 1; digit d>0 is 1 iff any digit >=d is nonzero)

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, bcd=0, ovf=0, sig_mask={{DIGITS-1{0}},1}; count and shift register cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load the bin shift register, clear the BCD accumulator and ovf, set count=BIN_W, go to SHIFT.
- SHIFT (in_ready=0, out_valid=0), each cycle:
  - Every digit >=5 gets +3 (4-bit, no carry between digits).
  - Then the whole {digits, bin} vector shifts left by one; bin MSB enters digit 0 LSB.
  - If the bit shifted out of the top digit is 1, set ovf (sticky for this conversion).
  - count decrements. When count reaches 1 before the shift, the shift completes, the state goes to DONE, and sig_mask is computed from the final digits in the same edge.
- Latency: accept edge k -> exactly BIN_W SHIFT cycles -> out_valid=1 after edge k+BIN_W.
- DONE:
  - out_valid=1; bcd, ovf and sig_mask held stable until out_ready=1.
  - out_valid&out_ready with in_valid=0: go to IDLE; out_valid=0 next cycle.
  - Back-to-back: in_ready = (state==IDLE) | (state==DONE & out_ready). If the result handshake and a new in_valid coincide, the new operand loads and the state goes to SHIFT directly, with no idle bubble.
- bcd, ovf and sig_mask keep the previous result while SHIFT is in progress. Only the internal accumulator changes; outputs are registered copies updated on entry to DONE.
- in_valid while in SHIFT or in DONE without out_ready: ignored; the source must hold the value (standard valid/ready, no drop).
- bin=0: bcd=0, ovf=0, sig_mask=...0001.
- Reset mid-SHIFT or in DONE: conversion abandoned, all outputs return to reset values immediately, no partial result emitted.
- Widths: count is $clog2(BIN_W+1) bits. The accumulator is exactly 4*DIGITS bits, so no extra guard digit.

Decomposition:
- Shared package bcd_pkg:
  - localparam function for the minimum digits for a width (ceil(BIN_W*log10 2)), used by instantiators.
  - State enum {IDLE, SHIFT, DONE}.
  - Constant ADD3_THRESH=4'd5.
- One natural sub-module: bcd_digit_adj (4-bit in, 4-bit out, +3 if >=5), instantiated DIGITS times in a generate loop.
- Leading-zero mask: a simple OR-scan inside the top level.

Test Plan:
- BIN_W=10, DIGITS=4, bin=1023 -> bcd=16'h1023, ovf=0, sig_mask=4'b1111, out_valid rises exactly 10 cycles after accept.
- bin=0, then bin=7, then bin=999 -> bcd 16'h0000/16'h0007/16'h0999, sig_mask 4'b0001/4'b0001/4'b0111.
- BIN_W=8, DIGITS=2, bin=255 -> bcd=8'h55, ovf=1. Then bin=99 -> bcd=8'h99, ovf=0 (ovf not sticky across conversions).
- Backpressure: out_ready=0 for 5 cycles after out_valid -> bcd stable, in_ready=0, a held in_valid is not accepted. Raise out_ready with in_valid=1 -> new operand accepted in the same cycle; next result arrives 10 cycles later.
- Randomised stream of 1000 values with random in_valid/out_ready -> every bcd equals the reference decimal of bin, in order, with no drops or duplicates.
- Assert rst_n low at SHIFT cycle 4 -> out_valid=0 and in_ready=1 immediately. After release, bin=512 converts to 16'h0512 cleanly.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bcd_pkg;

  // Converter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // A BCD digit at or above this value receives +3 before each shift
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  // Minimum digit count that holds 2^bin_w-1: ceil(bin_w * log10(2)).
  // log10(2) is approximated as 0.30103; the error cannot move the ceiling
  // for any practical width. Intended for parameter expressions.
  function automatic int min_digits(input int bin_w);
    int d;
    d = (bin_w * 30103 + 99999) / 100000;
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more.
// The result is 4 bits; there is no carry into the next digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= ADD3_THRESH) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Multi-cycle binary-to-BCD converter, one double-dabble shift per clock,
// with valid/ready on both sides, overflow flag and leading-zero mask.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for an operand, in_ready=1
// SHIFT | BIN_W add-3/shift steps on the internal accumulator
// DONE  | result presented on bcd/ovf/sig_mask, waiting for out_ready
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic [DIGITS-1:0]     sig_mask
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_e             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [BIN_W-1:0]   r_bin;
  logic [BCD_W-1:0]   r_acc;
  logic               r_ovf_acc;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_ovf;
  logic [DIGITS-1:0]  r_sig_mask;

  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_acc_next;
  logic               w_ovf_next;
  logic [DIGITS-1:0]  w_mask_next;
  logic               w_accept;
  logic               w_last;

  // A new operand may also be taken in DONE when the result leaves on the
  // same edge, so back-to-back conversions have no idle bubble.
  assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_count == CNT_LAST);

  assign bcd      = r_bcd;
  assign ovf      = r_ovf;
  assign sig_mask = r_sig_mask;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_acc[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  // The bit leaving the top digit is a dropped 10^DIGITS carry: overflow.
  assign w_acc_next = {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
  assign w_ovf_next = r_ovf_acc | w_adj[BCD_W-1];

  // Significance scan from the top digit down; digit 0 is always shown
  always_comb begin
    w_mask_next = '0;
    w_mask_next[DIGITS-1] = |w_acc_next[BCD_W-1 -: 4];
    for (int d = DIGITS - 2; d >= 0; d--) begin
      w_mask_next[d] = (|w_acc_next[4*d +: 4]) | w_mask_next[d+1];
    end
    w_mask_next[0] = 1'b1;
  end

  // Control FSM, shift register and BCD accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_bin     <= '0;
      r_acc     <= '0;
      r_ovf_acc <= 1'b0;
    end else if (w_accept) begin
      r_state   <= SHIFT;
      r_count   <= CNT_LOAD;
      r_bin     <= bin;
      r_acc     <= '0;
      r_ovf_acc <= 1'b0;
    end else begin
      case (r_state)
        SHIFT: begin
          r_acc     <= w_acc_next;
          r_bin     <= {r_bin[BIN_W-2:0], 1'b0};
          r_ovf_acc <= w_ovf_next;
          r_count   <= r_count - 1'b1;
          if (w_last) r_state <= DONE;
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        IDLE: ;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Result registers: updated only on the final shift, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
      r_sig_mask <= DIGITS'(1);
    end else if ((r_state == SHIFT) && w_last) begin
      r_bcd      <= w_acc_next;
      r_ovf      <= w_ovf_next;
      r_sig_mask <= w_mask_next;
    end
  end

endmodule
